// File: rtl/ahb_bridge_arbiter.sv
// Two-master AHB-lite arbiter in front of the AHB-to-APB bridge slave port.
// Round-robin grant with a per-tenure NSEQ quota; write data follows the data-phase owner.
module ahb_bridge_arbiter #(
    parameter int unsigned MAX_HOLD       = 4,
    parameter bit          DEFAULT_MASTER = 1'b0
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        m0_hbusreq,
    input  logic        m1_hbusreq,
    input  logic [31:0] m0_haddr,
    input  logic [31:0] m1_haddr,
    input  logic [1:0]  m0_htrans,
    input  logic [1:0]  m1_htrans,
    input  logic        m0_hwrite,
    input  logic        m1_hwrite,
    input  logic [2:0]  m0_hsize,
    input  logic [2:0]  m1_hsize,
    input  logic [2:0]  m0_hburst,
    input  logic [2:0]  m1_hburst,
    input  logic [31:0] m0_hwdata,
    input  logic [31:0] m1_hwdata,
    input  logic        hreadys,
    output logic        m0_hgrant,
    output logic        m1_hgrant,
    output logic        hmaster,
    output logic        hmaster_data,
    output logic        hsels,
    output logic [31:0] haddrs,
    output logic        hwrites,
    output logic [1:0]  htranss,
    output logic [2:0]  hsizes,
    output logic [2:0]  hbursts,
    output logic [31:0] hwdatas
);

    typedef enum logic [1:0] {PARK, GNT0, GNT1} state_t;

    localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);
    localparam logic [4:0] HOLD_LIM = 5'(MAX_HOLD);

    state_t     state, state_nxt;
    logic [3:0] hold_cnt, hold_nxt;
    logic       grant_nxt;
    logic       accepted;
    logic       quota_hit;

    always_comb begin
        haddrs  = hmaster ? m1_haddr  : m0_haddr;
        hwrites = hmaster ? m1_hwrite : m0_hwrite;
        htranss = hmaster ? m1_htrans : m0_htrans;
        hsizes  = hmaster ? m1_hsize  : m0_hsize;
        hbursts = hmaster ? m1_hburst : m0_hburst;
        hwdatas = hmaster_data ? m1_hwdata : m0_hwdata;
        hsels   = htranss[1];
    end

    assign accepted  = hsels & hreadys & (htranss == 2'b10);
    // The quota is judged on the count this accepted NSEQ would produce.
    assign quota_hit = accepted & (({1'b0, hold_cnt} + 5'd1) >= HOLD_LIM);

    always_comb begin
        state_nxt = state;
        case (state)
            PARK: begin
                if (m0_hbusreq && m1_hbusreq)
                    state_nxt = DEFAULT_MASTER ? GNT0 : GNT1;
                else if (m0_hbusreq)
                    state_nxt = GNT0;
                else if (m1_hbusreq)
                    state_nxt = GNT1;
            end
            GNT0: begin
                if (m1_hbusreq && (!m0_hbusreq || quota_hit))
                    state_nxt = GNT1;
                else if (!m0_hbusreq && !m1_hbusreq)
                    state_nxt = PARK;
            end
            GNT1: begin
                if (m0_hbusreq && (!m1_hbusreq || quota_hit))
                    state_nxt = GNT0;
                else if (!m0_hbusreq && !m1_hbusreq)
                    state_nxt = PARK;
            end
            default: state_nxt = PARK;
        endcase
    end

    always_comb begin
        hold_nxt = hold_cnt;
        if (state_nxt != state)
            hold_nxt = '0;
        else if ((state != PARK) && accepted && (hold_cnt < HOLD_MAX))
            hold_nxt = hold_cnt + 4'd1;
    end

    always_comb begin
        case (state_nxt)
            GNT0:    grant_nxt = 1'b0;
            GNT1:    grant_nxt = 1'b1;
            default: grant_nxt = DEFAULT_MASTER;
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state        <= PARK;
            hold_cnt     <= '0;
            hmaster      <= DEFAULT_MASTER;
            hmaster_data <= DEFAULT_MASTER;
            m0_hgrant    <= ~DEFAULT_MASTER;
            m1_hgrant    <= DEFAULT_MASTER;
        end else if (hreadys) begin
            state        <= state_nxt;
            hold_cnt     <= hold_nxt;
            hmaster      <= grant_nxt;
            hmaster_data <= hmaster;
            m0_hgrant    <= ~grant_nxt;
            m1_hgrant    <= grant_nxt;
        end
    end

endmodule

// File: tb/tb_ahb_bridge_arbiter.sv
// Scoreboard bench for ahb_bridge_arbiter: directed stimulus pushes expected transfers,
// a negedge monitor pops and checks address phase and data phase.
module tb_ahb_bridge_arbiter;

    logic        hclk = 1'b0;
    logic        hresetn = 1'b0;
    logic        m0_hbusreq = 1'b0, m1_hbusreq = 1'b0;
    logic [31:0] m0_haddr = '0, m1_haddr = '0;
    logic [1:0]  m0_htrans, m1_htrans;
    logic        m0_hwrite = 1'b0, m1_hwrite = 1'b0;
    logic [2:0]  m0_hsize = 3'd2, m1_hsize = 3'd2;
    logic [2:0]  m0_hburst = 3'd0, m1_hburst = 3'd0;
    logic [31:0] m0_hwdata = '0, m1_hwdata = '0;
    logic        hreadys = 1'b1;
    logic        m0_hgrant, m1_hgrant, hmaster, hmaster_data, hsels;
    logic [31:0] haddrs, hwdatas;
    logic        hwrites;
    logic [1:0]  htranss;
    logic [2:0]  hsizes, hbursts;

    logic want0 = 1'b0, want1 = 1'b0;
    logic bridge_en = 1'b1, auto_inc = 1'b0;

    // Masters only drive NSEQ while they hold the grant.
    assign m0_htrans = (want0 && m0_hgrant) ? 2'b10 : 2'b00;
    assign m1_htrans = (want1 && m1_hgrant) ? 2'b10 : 2'b00;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        m;
        logic [31:0] a;
        logic        w;
        logic [31:0] d;
    } xfer_t;
    xfer_t exp_q[$];

    ahb_bridge_arbiter #(.MAX_HOLD(4), .DEFAULT_MASTER(1'b0)) dut (
        .hclk(hclk), .hresetn(hresetn),
        .m0_hbusreq(m0_hbusreq), .m1_hbusreq(m1_hbusreq),
        .m0_haddr(m0_haddr), .m1_haddr(m1_haddr),
        .m0_htrans(m0_htrans), .m1_htrans(m1_htrans),
        .m0_hwrite(m0_hwrite), .m1_hwrite(m1_hwrite),
        .m0_hsize(m0_hsize), .m1_hsize(m1_hsize),
        .m0_hburst(m0_hburst), .m1_hburst(m1_hburst),
        .m0_hwdata(m0_hwdata), .m1_hwdata(m1_hwdata),
        .hreadys(hreadys),
        .m0_hgrant(m0_hgrant), .m1_hgrant(m1_hgrant),
        .hmaster(hmaster), .hmaster_data(hmaster_data),
        .hsels(hsels), .haddrs(haddrs), .hwrites(hwrites),
        .htranss(htranss), .hsizes(hsizes), .hbursts(hbursts),
        .hwdatas(hwdatas)
    );

    always #5 hclk = ~hclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic acc_now();
        return hsels && hreadys && (htranss == 2'b10);
    endfunction

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic wait_acc(input string name);
        int n = 0;
        @(negedge hclk);
        while (!acc_now() && n < 200) begin
            @(negedge hclk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL %s timeout actual=no_transfer required=transfer", name);
        end
        step();
    endtask

    // Scoreboard monitor
    logic  dp_pend = 1'b0;
    xfer_t dp;
    always @(negedge hclk) begin
        if (!hresetn) begin
            dp_pend = 1'b0;
        end else begin
            if (dp_pend && hreadys) begin
                chk("dphase_owner", 32'(hmaster_data), 32'(dp.m));
                if (dp.w) chk("hwdatas", hwdatas, dp.d);
                dp_pend = 1'b0;
            end
            if (acc_now()) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_xfer actual=%h required=none", haddrs);
                end else begin
                    xfer_t x;
                    x = exp_q.pop_front();
                    chk("aphase_owner", 32'(hmaster), 32'(x.m));
                    chk("haddrs", haddrs, x.a);
                    chk("hwrites", 32'(hwrites), 32'(x.w));
                    dp = x;
                    dp_pend = 1'b1;
                end
            end
        end
    end

    // Bridge model: every accepted transfer takes 3 cycles (two wait states).
    initial begin
        logic a, am;
        int   busy = 0;
        forever begin
            @(negedge hclk);
            a  = acc_now();
            am = hmaster;
            @(posedge hclk);
            #1;
            if (!hresetn) begin
                busy = 0;
            end else if (bridge_en) begin
                if (a) begin
                    hreadys = 1'b0;
                    busy = 2;
                end else if (busy > 0) begin
                    busy--;
                    hreadys = (busy == 0);
                end
            end
            if (auto_inc && a) begin
                if (am) m1_haddr = m1_haddr + 32'd4;
                else    m0_haddr = m0_haddr + 32'd4;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset, no requests
        repeat (3) step();
        hresetn = 1'b1;
        @(negedge hclk);
        chk("rst_m0_hgrant", 32'(m0_hgrant), 32'd1);
        chk("rst_m1_hgrant", 32'(m1_hgrant), 32'd0);
        chk("rst_hmaster", 32'(hmaster), 32'd0);
        chk("rst_hsels", 32'(hsels), 32'd0);
        chk("rst_hmaster_data", 32'(hmaster_data), 32'd0);

        // Single m1 write
        step();
        m1_hbusreq = 1'b1;
        m1_haddr   = 32'h1000_0004;
        m1_hwrite  = 1'b1;
        m1_hwdata  = 32'hA5A5_0001;
        want1      = 1'b1;
        exp_q.push_back('{m: 1'b1, a: 32'h1000_0004, w: 1'b1, d: 32'hA5A5_0001});
        step();
        chk("m1_grant", 32'(m1_hgrant), 32'd1);
        chk("m1_grant_m0", 32'(m0_hgrant), 32'd0);
        chk("m1_hmaster", 32'(hmaster), 32'd1);
        wait_acc("m1_write");
        want1      = 1'b0;
        m1_hbusreq = 1'b0;
        repeat (6) step();

        // Round robin with quota of 4
        m0_haddr   = 32'h1000_0000;
        m1_haddr   = 32'h2000_0000;
        m0_hwrite  = 1'b0;
        m1_hwrite  = 1'b0;
        auto_inc   = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back('{m: 1'b1, a: 32'h2000_0000 + 32'(4 * i), w: 1'b0, d: '0});
        for (int i = 0; i < 4; i++) exp_q.push_back('{m: 1'b0, a: 32'h1000_0000 + 32'(4 * i), w: 1'b0, d: '0});
        for (int i = 0; i < 4; i++) exp_q.push_back('{m: 1'b1, a: 32'h2000_0010 + 32'(4 * i), w: 1'b0, d: '0});
        m0_hbusreq = 1'b1;
        m1_hbusreq = 1'b1;
        step();
        chk("tie_park_m1", 32'(m1_hgrant), 32'd1);
        want0 = 1'b1;
        want1 = 1'b1;
        for (int i = 0; i < 12; i++) wait_acc("rr_xfer");
        want0      = 1'b0;
        want1      = 1'b0;
        m0_hbusreq = 1'b0;
        m1_hbusreq = 1'b0;
        auto_inc   = 1'b0;
        repeat (6) step();

        // Owner m0 releases on the edge its last NSEQ is accepted
        m0_hbusreq = 1'b1;
        m0_haddr   = 32'h3000_0000;
        m0_hwrite  = 1'b1;
        m0_hwdata  = 32'hD0D0_0000;
        m1_hwdata  = 32'h1111_1111;
        m1_haddr   = 32'h3000_0100;
        m1_hwrite  = 1'b1;
        step();
        @(negedge hclk);
        chk("ho_m0_grant", 32'(m0_hgrant), 32'd1);
        step();
        want0      = 1'b1;
        m0_hbusreq = 1'b0;
        m1_hbusreq = 1'b1;
        exp_q.push_back('{m: 1'b0, a: 32'h3000_0000, w: 1'b1, d: 32'hD0D0_0000});
        step();
        chk("ho_hmaster", 32'(hmaster), 32'd1);
        chk("ho_m1_grant", 32'(m1_hgrant), 32'd1);
        chk("ho_hmaster_data", 32'(hmaster_data), 32'd0);
        want0      = 1'b0;
        m1_hbusreq = 1'b0;
        repeat (6) step();

        // Grant held through a 2-cycle error response
        bridge_en  = 1'b0;
        hreadys    = 1'b1;
        m0_hbusreq = 1'b1;
        step();
        chk("err_m0_grant", 32'(m0_hgrant), 32'd1);
        hreadys    = 1'b0;
        m0_hbusreq = 1'b0;
        m1_hbusreq = 1'b1;
        step();
        chk("err_hold1_m0", 32'(m0_hgrant), 32'd1);
        chk("err_hold1_hm", 32'(hmaster), 32'd0);
        step();
        chk("err_hold2_m0", 32'(m0_hgrant), 32'd1);
        hreadys = 1'b1;
        step();
        chk("err_sw_m1", 32'(m1_hgrant), 32'd1);
        chk("err_sw_m0", 32'(m0_hgrant), 32'd0);
        chk("err_sw_hm", 32'(hmaster), 32'd1);

        // Reset pulsed during GNT1 with hreadys low
        m1_haddr  = 32'h4000_0000;
        m1_hwrite = 1'b0;
        want1     = 1'b1;
        exp_q.push_back('{m: 1'b1, a: 32'h4000_0000, w: 1'b0, d: '0});
        wait_acc("rst_setup");
        want1   = 1'b0;
        hreadys = 1'b0;
        chk("pre_rst_hold_cnt", 32'(dut.hold_cnt), 32'd1);
        #2;
        hresetn = 1'b0;
        #1;
        chk("arst_m0_hgrant", 32'(m0_hgrant), 32'd1);
        chk("arst_m1_hgrant", 32'(m1_hgrant), 32'd0);
        chk("arst_hmaster", 32'(hmaster), 32'd0);
        chk("arst_hold_cnt", 32'(dut.hold_cnt), 32'd0);
        step();
        m1_hbusreq = 1'b0;
        hreadys    = 1'b1;
        hresetn    = 1'b1;
        repeat (3) step();

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
